// File: rtl/vigna_dmem_responder.sv
// vigna data-bus memory responder.
// Serves word reads and byte-strobed writes from an internal word-addressed RAM.
// The response latency is set by a parameter.
// A backdoor word port preloads the RAM without bus traffic.
module vigna_dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  d_valid,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_ready,
    output logic [31:0]           d_rdata,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [31:0]           init_wdata,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte-lane merge: lanes enabled in strb take data, the rest keep base.
    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = base;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end else begin
                res[8*k +: 8] = base[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]           r_mem [0:DEPTH-1];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_ready;
    logic                  r_busy;
    logic [31:0]           r_rdata;

    state_t                w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_wstrb;
    logic [31:0]           w_old_word;
    logic [31:0]           w_base_word;
    logic [31:0]           w_new_word;
    logic                  w_unused_addr_bits;

    // Address bits above the RAM depth alias; bits [1:0] select bytes and are ignored.
    assign w_req_idx          = d_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr_bits = ^{d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

    // Next-state logic.
    // The access commits on the edge that enters RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Access fields.
    // When LATENCY is 0 the access coincides with acceptance, so the live bus fields are used.
    // Otherwise the fields latched at acceptance are used.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_idx   = w_req_idx;
            w_acc_wdata = d_wdata;
            w_acc_wstrb = d_wstrb;
        end else begin
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
            w_acc_wstrb = r_wstrb;
        end
    end

    // Pre-write word, and the merged word for a bus write.
    // If the backdoor writes the same word on the same edge, its data fills the lanes the bus leaves untouched.
    always_comb begin
        w_old_word = r_mem[w_acc_idx];
        if (init_we && (init_addr == w_acc_idx)) begin
            w_base_word = init_wdata;
        end else begin
            w_base_word = w_old_word;
        end
        w_new_word = merge_bytes(w_base_word, w_acc_wdata, w_acc_wstrb);
    end

    // Transaction FSM with registered d_ready, busy and read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RESP);
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_idx   <= w_req_idx;
                r_wdata <= d_wdata;
                r_wstrb <= d_wstrb;
            end else begin
                r_idx   <= r_idx;
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
            end
            if (w_commit) begin
                r_rdata <= w_old_word;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    // RAM write port (not reset).
    // A bus write is dropped while reset is asserted.
    // On a collision the bus write is issued last, so it carries the merged word.
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[init_addr] <= init_wdata;
        end
        if (resetn && w_commit && (w_acc_wstrb != 4'd0)) begin
            r_mem[w_acc_idx] <= w_new_word;
        end
    end

    assign d_ready = r_ready;
    assign d_rdata = r_rdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_vigna_dmem_responder.sv
// Scoreboard bench for vigna_dmem_responder.
// u=0 is an instance with LATENCY=0; u=1 is an instance with LATENCY=3.
module tb_vigna_dmem_responder;

    localparam int AW = 8;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          d_valid    [2];
    logic [31:0]   d_addr     [2];
    logic [31:0]   d_wdata    [2];
    logic [3:0]    d_wstrb    [2];
    logic          d_ready    [2];
    logic [31:0]   d_rdata    [2];
    logic          init_we    [2];
    logic [AW-1:0] init_addr  [2];
    logic [31:0]   init_wdata [2];
    logic          busy       [2];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_rdata [2];
    int          brun       [2];

    vigna_dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .d_valid(d_valid[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wstrb(d_wstrb[0]),
        .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
        .init_we(init_we[0]), .init_addr(init_addr[0]), .init_wdata(init_wdata[0]),
        .busy(busy[0])
    );

    vigna_dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(3)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .d_valid(d_valid[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wstrb(d_wstrb[1]),
        .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
        .init_we(init_we[1]), .init_addr(init_addr[1]), .init_wdata(init_wdata[1]),
        .busy(busy[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter, used to time the expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s u=%0d got=%h want=%h", nm, u, got, want);
        end
    endtask

    // Monitor for one instance.
    // It pops the scoreboard on d_ready, checks that d_rdata holds between responses, and checks the length of each busy run.
    task automatic mon(input int u);
        exp_t e;
        bit   empty;
        if (!resetn) begin
            last_rdata[u] = 32'd0;
            brun[u]       = 0;
            return;
        end
        if (d_ready[u]) begin
            empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
            total++;
            if (empty) begin
                bad++;
                $display("FAIL unexpected_ready u=%0d got d_ready=1 at cyc=%0d want 0", u, cyc);
            end else begin
                if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (d_rdata[u] !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL resp u=%0d got data=%h cyc=%0d want data=%h cyc=%0d",
                             u, d_rdata[u], cyc, e.data, e.cyc);
                end
            end
            last_rdata[u] = d_rdata[u];
        end else begin
            chk("rdata_hold", u, d_rdata[u], last_rdata[u]);
        end
        if (busy[u]) begin
            brun[u]++;
        end else if (brun[u] != 0) begin
            chk("busy_len", u, 32'(brun[u]), 32'(lat_of(u) + 1));
            brun[u] = 0;
        end
    endtask

    // Output sampling on the inactive edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon(u);
    end

    task automatic preload(input int u, input logic [AW-1:0] idx, input logic [31:0] data);
        init_we[u]    = 1'b1;
        init_addr[u]  = idx;
        init_wdata[u] = data;
        @(posedge clk); #1;
        init_we[u] = 1'b0;
    endtask

    // Issue one request.
    // The call is made 1ns after an edge with the DUT idle, so acceptance is the next edge.
    // keep: leave d_valid high for a back-to-back request.
    // drop: release d_valid and scramble the bus fields just after acceptance.
    task automatic req(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] want, input bit keep, input bit drop);
        exp_t e;
        int   lat;
        lat         = lat_of(u);
        d_valid[u]  = 1'b1;
        d_addr[u]   = addr;
        d_wdata[u]  = wdata;
        d_wstrb[u]  = strb;
        e.data      = want;
        e.cyc       = cyc + 1 + lat;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        init_we[u] = 1'b0;
        if (drop) begin
            d_valid[u] = 1'b0;
            d_addr[u]  = 32'h0000_0000;
            d_wdata[u] = 32'h0000_0000;
            d_wstrb[u] = 4'hF;
        end
        if (lat > 0) begin
            repeat (lat) @(posedge clk);
            #1;
        end
        if (!keep) d_valid[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            d_valid[u]    = 1'b0;
            d_addr[u]     = 32'd0;
            d_wdata[u]    = 32'd0;
            d_wstrb[u]    = 4'd0;
            init_we[u]    = 1'b0;
            init_addr[u]  = '0;
            init_wdata[u] = 32'd0;
            last_rdata[u] = 32'd0;
            brun[u]       = 0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_ready", u, {31'd0, d_ready[u]}, 32'd0);
            chk("reset_rdata", u, d_rdata[u], 32'd0);
            chk("reset_busy",  u, {31'd0, busy[u]}, 32'd0);
        end

        // ---------------- LATENCY = 0 ----------------
        preload(0, 8'd0, 32'h3F80_0000);
        preload(0, 8'd1, 32'h4000_0000);
        preload(0, 8'd2, 32'h1122_3344);
        preload(0, 8'd5, 32'hA5A5_A5A5);
        req(0, 32'h0000_0000, 32'd0, 4'b0000, 32'h3F80_0000, 1'b0, 1'b0);
        req(0, 32'h0000_0004, 32'd0, 4'b0000, 32'h4000_0000, 1'b0, 1'b0);
        req(0, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, 1'b0, 1'b0);
        req(0, 32'h0000_0008, 32'd0, 4'b0000, 32'h11BB_33DD, 1'b0, 1'b0);
        req(0, 32'h0000_0408, 32'd0, 4'b0000, 32'h11BB_33DD, 1'b0, 1'b0);
        // Collision: the bus byte write and the backdoor word write hit word 5 on the same edge.
        init_we[0]    = 1'b1;
        init_addr[0]  = 8'd5;
        init_wdata[0] = 32'h1234_5678;
        req(0, 32'h0000_0014, 32'h0000_00FF, 4'b0001, 32'hA5A5_A5A5, 1'b0, 1'b0);
        req(0, 32'h0000_0014, 32'd0, 4'b0000, 32'h1234_56FF, 1'b0, 1'b0);
        // Back-to-back reads with d_valid held high throughout.
        req(0, 32'h0000_0000, 32'd0, 4'b0000, 32'h3F80_0000, 1'b1, 1'b0);
        req(0, 32'h0000_0004, 32'd0, 4'b0000, 32'h4000_0000, 1'b1, 1'b0);
        req(0, 32'h0000_0008, 32'd0, 4'b0000, 32'h11BB_33DD, 1'b0, 1'b0);

        // ---------------- LATENCY = 3 ----------------
        preload(1, 8'd0, 32'h3F80_0000);
        preload(1, 8'd1, 32'h4000_0000);
        preload(1, 8'd2, 32'h1122_3344);
        preload(1, 8'd4, 32'hCAFE_F00D);
        req(1, 32'h0000_0404, 32'd0, 4'b0000, 32'h4000_0000, 1'b0, 1'b0);
        req(1, 32'h0000_0000, 32'd0, 4'b0000, 32'h3F80_0000, 1'b1, 1'b0);
        req(1, 32'h0000_0004, 32'd0, 4'b0000, 32'h4000_0000, 1'b1, 1'b0);
        req(1, 32'h0000_0008, 32'd0, 4'b0000, 32'h1122_3344, 1'b0, 1'b0);
        // Protocol violation: d_valid is released and the bus fields are scrambled after acceptance.
        req(1, 32'h0000_0008, 32'hAABB_CCDD, 4'b1111, 32'h1122_3344, 1'b0, 1'b1);
        req(1, 32'h0000_0008, 32'd0, 4'b0000, 32'hAABB_CCDD, 1'b0, 1'b0);
        req(1, 32'h0000_0000, 32'd0, 4'b0000, 32'h3F80_0000, 1'b0, 1'b0);

        // Reset asserted in WAIT of a pending write; the write must be dropped.
        d_valid[1] = 1'b1;
        d_addr[1]  = 32'h0000_0010;
        d_wdata[1] = 32'hDEAD_BEEF;
        d_wstrb[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn     = 1'b0;
        d_valid[1] = 1'b0;
        #1;
        chk("midreset_ready", 1, {31'd0, d_ready[1]}, 32'd0);
        chk("midreset_busy",  1, {31'd0, busy[1]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        req(1, 32'h0000_0010, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        chk("q0_drained", 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", 1, 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
